// File: rtl/lab5_pkg.sv
// Shared opcodes, bus-mux selects, ALU function codes and FSM states for the Lab5 controller.
package lab5_pkg;

    localparam logic [2:0] OP_LDC = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_INC = 3'd3;
    localparam logic [2:0] OP_DEC = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_MOV = 3'd7;

    localparam logic [2:0] BS_C0  = 3'd0;
    localparam logic [2:0] BS_C1  = 3'd1;
    localparam logic [2:0] BS_C2  = 3'd2;
    localparam logic [2:0] BS_C4  = 3'd3;
    localparam logic [2:0] BS_REG = 3'd4;
    localparam logic [2:0] BS_ALU = 3'd5;

    localparam logic [2:0] ALU_NOP = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_INC = 3'd3;
    localparam logic [2:0] ALU_DEC = 3'd4;
    localparam logic [2:0] ALU_AND = 3'd5;
    localparam logic [2:0] ALU_MUL = 3'd6;

    typedef enum logic [3:0] {
        StIdle = 4'd0,
        StRdA  = 4'd1,
        StMuxA = 4'd2,
        StLdA  = 4'd3,
        StRdB  = 4'd4,
        StMuxB = 4'd5,
        StLdB  = 4'd6,
        StExec = 4'd7,
        StMuxR = 4'd8,
        StMuxC = 4'd9,
        StWb   = 4'd10
    } state_e;

    // Opcode to datapath ALU function; LDC and MOV never drive the ALU.
    function automatic logic [2:0] op_to_alu(input logic [2:0] op);
        logic [2:0] alu;
        alu = ALU_NOP;
        case (op)
            OP_ADD:  alu = ALU_ADD;
            OP_SUB:  alu = ALU_SUB;
            OP_INC:  alu = ALU_INC;
            OP_DEC:  alu = ALU_DEC;
            OP_AND:  alu = ALU_AND;
            OP_MUL:  alu = ALU_MUL;
            default: alu = ALU_NOP;
        endcase
        return alu;
    endfunction

    // LDC constant select from rs1[1:0]: 0/1/2/4.
    function automatic logic [2:0] const_sel(input logic [1:0] sel);
        logic [2:0] bs;
        bs = BS_C0;
        case (sel)
            2'd0:    bs = BS_C0;
            2'd1:    bs = BS_C1;
            2'd2:    bs = BS_C2;
            default: bs = BS_C4;
        endcase
        return bs;
    endfunction

endpackage

// File: rtl/lab5_ctrl_decode.sv
// Combinational opcode decode into the three sequence-path flags used by the controller FSM.
module lab5_ctrl_decode
    import lab5_pkg::*;
(
    input  logic [2:0] i_op,
    output logic       o_is_const,
    output logic       o_is_move,
    output logic       o_needs_b
);

    always_comb begin
        o_is_const = 1'b0;
        o_is_move  = 1'b0;
        o_needs_b  = 1'b0;
        case (i_op)
            OP_LDC:  o_is_const = 1'b1;
            OP_MOV:  o_is_move  = 1'b1;
            OP_ADD,
            OP_SUB,
            OP_AND,
            OP_MUL:  o_needs_b  = 1'b1;
            default: o_needs_b  = 1'b0;
        endcase
    end

endmodule

// File: rtl/lab5_controller.sv
// Lab5 instruction sequencer: expands one handshaked instruction into registered datapath
// control steps. Optional retired-instruction counter enabled by LAB5_CTRL_PERF_EN.
module lab5_controller
    import lab5_pkg::*;
#(
    parameter int unsigned PERF_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [2:0]        instr_rd,
    input  logic [2:0]        instr_rs1,
    input  logic [2:0]        instr_rs2,
    output logic              done,
    output logic [2:0]        wA,
    output logic [2:0]        rA,
    output logic              rW,
    output logic [2:0]        BS,
    output logic              WrA,
    output logic              WrB,
    output logic [2:0]        ALUop,
    output logic [PERF_W-1:0] instr_count
);

    state_e     r_state;
    state_e     w_state_d;

    logic [2:0] r_op;
    logic [2:0] r_rd;
    logic [2:0] r_rs1;
    logic [2:0] r_rs2;

    logic       r_ready;
    logic       r_done;
    logic [2:0] r_wa;
    logic [2:0] r_ra;
    logic       r_rw;
    logic [2:0] r_bs;
    logic       r_wra;
    logic       r_wrb;
    logic [2:0] r_aluop;

    logic       w_ready_d;
    logic       w_done_d;
    logic [2:0] w_wa_d;
    logic [2:0] w_ra_d;
    logic       w_rw_d;
    logic [2:0] w_bs_d;
    logic       w_wra_d;
    logic       w_wrb_d;
    logic [2:0] w_aluop_d;

    logic       w_accept;
    logic [2:0] w_op;
    logic [2:0] w_rd;
    logic [2:0] w_rs1;
    logic [2:0] w_rs2;
    logic       w_is_const;
    logic       w_is_move;
    logic       w_needs_b;

    assign w_accept = instr_valid && r_ready;

    // Fields come straight from the inputs in the accept cycle so the first step can be registered.
    assign w_op  = w_accept ? instr_op  : r_op;
    assign w_rd  = w_accept ? instr_rd  : r_rd;
    assign w_rs1 = w_accept ? instr_rs1 : r_rs1;
    assign w_rs2 = w_accept ? instr_rs2 : r_rs2;

    lab5_ctrl_decode u_decode (
        .i_op       (w_op),
        .o_is_const (w_is_const),
        .o_is_move  (w_is_move),
        .o_needs_b  (w_needs_b)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op  <= OP_LDC;
            r_rd  <= 3'd0;
            r_rs1 <= 3'd0;
            r_rs2 <= 3'd0;
        end else if (w_accept) begin
            r_op  <= instr_op;
            r_rd  <= instr_rd;
            r_rs1 <= instr_rs1;
            r_rs2 <= instr_rs2;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = StIdle;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d = w_is_const ? StMuxC : StRdA;
                end else begin
                    w_state_d = StIdle;
                end
            end
            StRdA:   w_state_d = StMuxA;
            StMuxA:  w_state_d = w_is_move ? StWb : StLdA;
            StLdA:   w_state_d = w_needs_b ? StRdB : StExec;
            StRdB:   w_state_d = StMuxB;
            StMuxB:  w_state_d = StLdB;
            StLdB:   w_state_d = StExec;
            StExec:  w_state_d = StMuxR;
            StMuxR:  w_state_d = StWb;
            StMuxC:  w_state_d = StWb;
            StWb:    w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Next-cycle outputs are decoded from the next state, then registered below.
    always_comb begin
        w_ready_d = 1'b0;
        w_done_d  = 1'b0;
        w_wa_d    = 3'd0;
        w_ra_d    = 3'd0;
        w_rw_d    = 1'b1;
        w_bs_d    = BS_C0;
        w_wra_d   = 1'b1;
        w_wrb_d   = 1'b1;
        w_aluop_d = ALU_NOP;
        case (w_state_d)
            StIdle: begin
                w_ready_d = 1'b1;
                w_done_d  = (r_state == StWb);
            end
            StRdA: begin
                w_ra_d = w_rs1;
            end
            StMuxA: begin
                w_ra_d = w_rs1;
                w_bs_d = BS_REG;
            end
            StLdA: begin
                w_bs_d  = BS_REG;
                w_wra_d = 1'b0;
            end
            StRdB: begin
                w_ra_d = w_rs2;
            end
            StMuxB: begin
                w_ra_d = w_rs2;
                w_bs_d = BS_REG;
            end
            StLdB: begin
                w_bs_d  = BS_REG;
                w_wrb_d = 1'b0;
            end
            StExec: begin
                w_aluop_d = op_to_alu(w_op);
            end
            StMuxR: begin
                w_aluop_d = op_to_alu(w_op);
                w_bs_d    = BS_ALU;
            end
            StMuxC: begin
                w_bs_d = const_sel(w_rs1[1:0]);
            end
            StWb: begin
                // Bus source and ALU function stay put so the written value is stable.
                w_rw_d    = 1'b0;
                w_wa_d    = w_rd;
                w_bs_d    = r_bs;
                w_aluop_d = r_aluop;
            end
            default: begin
                w_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_wa    <= 3'd0;
            r_ra    <= 3'd0;
            r_rw    <= 1'b1;
            r_bs    <= BS_C0;
            r_wra   <= 1'b1;
            r_wrb   <= 1'b1;
            r_aluop <= ALU_NOP;
        end else begin
            r_ready <= w_ready_d;
            r_done  <= w_done_d;
            r_wa    <= w_wa_d;
            r_ra    <= w_ra_d;
            r_rw    <= w_rw_d;
            r_bs    <= w_bs_d;
            r_wra   <= w_wra_d;
            r_wrb   <= w_wrb_d;
            r_aluop <= w_aluop_d;
        end
    end

    assign instr_ready = r_ready;
    assign done        = r_done;
    assign wA          = r_wa;
    assign rA          = r_ra;
    assign rW          = r_rw;
    assign BS          = r_bs;
    assign WrA         = r_wra;
    assign WrB         = r_wrb;
    assign ALUop       = r_aluop;

`ifdef LAB5_CTRL_PERF_EN
    logic [PERF_W-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (r_done) begin
            r_count <= r_count + PERF_W'(1);
        end
    end

    assign instr_count = r_count;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_lab5_controller.sv
// Self-checking bench for lab5_controller: per-cycle control vectors versus a step-table model.
module tb_lab5_controller;

    localparam int PERF_W = 16;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [2:0]        instr_op = 3'd0;
    logic [2:0]        instr_rd = 3'd0;
    logic [2:0]        instr_rs1 = 3'd0;
    logic [2:0]        instr_rs2 = 3'd0;
    logic              done;
    logic [2:0]        wA;
    logic [2:0]        rA;
    logic              rW;
    logic [2:0]        BS;
    logic              WrA;
    logic              WrB;
    logic [2:0]        ALUop;
    logic [PERF_W-1:0] instr_count;

    int errors = 0;
    int checks = 0;
    int retired = 0;

    // {ready, done, wA, rA, rW, BS, WrA, WrB, ALUop}
    typedef logic [16:0] vec_t;
    localparam vec_t IdleV = {1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b1, 3'd0};
    localparam vec_t DoneV = {1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b1, 3'd0};

    vec_t obs;
    vec_t exp_q[$];

    assign obs = {instr_ready, done, wA, rA, rW, BS, WrA, WrB, ALUop};

    lab5_controller #(.PERF_W(PERF_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .done        (done),
        .wA          (wA),
        .rA          (rA),
        .rW          (rW),
        .BS          (BS),
        .WrA         (WrA),
        .WrB         (WrB),
        .ALUop       (ALUop),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    function automatic vec_t step(input logic [2:0] ra, input logic rw, input logic [2:0] bs,
                                  input logic wra, input logic wrb, input logic [2:0] alu,
                                  input logic [2:0] wa);
        return {1'b0, 1'b0, wa, ra, rw, bs, wra, wrb, alu};
    endfunction

    // Expected busy-cycle vectors for one instruction, straight from the step table.
    function automatic void build(input logic [2:0] op, input logic [2:0] rd,
                                  input logic [2:0] rs1, input logic [2:0] rs2);
        logic [2:0] last_bs;
        logic [2:0] last_alu;
        logic [1:0] csel;
        exp_q.delete();
        if (op == 3'd0) begin
            csel = rs1[1:0];
            last_bs  = {1'b0, csel};
            last_alu = 3'd0;
            exp_q.push_back(step(3'd0, 1'b1, last_bs, 1'b1, 1'b1, 3'd0, 3'd0));
        end else begin
            exp_q.push_back(step(rs1, 1'b1, 3'd0, 1'b1, 1'b1, 3'd0, 3'd0));
            exp_q.push_back(step(rs1, 1'b1, 3'd4, 1'b1, 1'b1, 3'd0, 3'd0));
            last_bs  = 3'd4;
            last_alu = 3'd0;
            if (op != 3'd7) begin
                exp_q.push_back(step(3'd0, 1'b1, 3'd4, 1'b0, 1'b1, 3'd0, 3'd0));
                if (op == 3'd1 || op == 3'd2 || op == 3'd5 || op == 3'd6) begin
                    exp_q.push_back(step(rs2, 1'b1, 3'd0, 1'b1, 1'b1, 3'd0, 3'd0));
                    exp_q.push_back(step(rs2, 1'b1, 3'd4, 1'b1, 1'b1, 3'd0, 3'd0));
                    exp_q.push_back(step(3'd0, 1'b1, 3'd4, 1'b1, 1'b0, 3'd0, 3'd0));
                end
                exp_q.push_back(step(3'd0, 1'b1, 3'd0, 1'b1, 1'b1, op, 3'd0));
                exp_q.push_back(step(3'd0, 1'b1, 3'd5, 1'b1, 1'b1, op, 3'd0));
                last_bs  = 3'd5;
                last_alu = op;
            end
        end
        exp_q.push_back(step(3'd0, 1'b0, last_bs, 1'b1, 1'b1, last_alu, rd));
    endfunction

    function automatic logic [PERF_W-1:0] exp_count();
`ifdef LAB5_CTRL_PERF_EN
        return PERF_W'(retired);
`else
        return '0;
`endif
    endfunction

    // Starts and ends on a falling edge with the DUT idle; ends in the done cycle.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input bit hold, input string tag);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_rd    = rd;
        instr_rs1   = rs1;
        instr_rs2   = rs2;
        build(op, rd, rs1, rs2);
        @(posedge clock);
        @(negedge clock);
        foreach (exp_q[i]) begin
            if (hold) begin
                instr_valid = 1'b1;
                instr_op    = op + 3'(1 + $urandom_range(6));
                instr_rd    = 3'($urandom_range(7));
                instr_rs1   = 3'($urandom_range(7));
                instr_rs2   = 3'($urandom_range(7));
            end else begin
                instr_valid = 1'b0;
            end
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL %s step %0d: got %h, required %h", tag, i, obs, exp_q[i]);
            end
            @(negedge clock);
        end
        instr_valid = 1'b0;
        checks++;
        if (obs !== DoneV) begin
            errors++;
            $display("FAIL %s done cycle: got %h, required %h", tag, obs, DoneV);
        end
        retired++;
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== IdleV) begin
                errors++;
                $display("FAIL %s idle %0d: got %h, required %h", tag, i, obs, IdleV);
            end
        end
    endtask

    task automatic check_count(input string tag);
        checks++;
        if (instr_count !== exp_count()) begin
            errors++;
            $display("FAIL %s instr_count: got %0d, required %0d", tag, instr_count, exp_count());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if (obs !== IdleV) begin
            errors++;
            $display("FAIL reset outputs: got %h, required %h", obs, IdleV);
        end
        check_count("reset");
        reset_n = 1'b1;
        idle_cycles(2, "post_reset");
    endtask

    task automatic test_directed();
        issue(3'd0, 3'd1, 3'd2, 3'd0, 1'b0, "ldc_r1_2");
        issue(3'd0, 3'd2, 3'd3, 3'd0, 1'b0, "ldc_r2_4");
        issue(3'd1, 3'd3, 3'd1, 3'd2, 1'b0, "add_r3");
        issue(3'd2, 3'd4, 3'd1, 3'd2, 1'b0, "sub_r4");
        issue(3'd3, 3'd4, 3'd4, 3'd0, 1'b0, "inc_r4_a");
        issue(3'd3, 3'd4, 3'd4, 3'd0, 1'b0, "inc_r4_b");
        issue(3'd6, 3'd5, 3'd2, 3'd2, 1'b0, "mul_r5");
        issue(3'd7, 3'd6, 3'd5, 3'd0, 1'b0, "mov_r6");
        issue(3'd4, 3'd0, 3'd6, 3'd0, 1'b0, "dec_r0");
        issue(3'd5, 3'd7, 3'd3, 3'd6, 1'b0, "and_r7");
        issue(3'd0, 3'd6, 3'd5, 3'd0, 1'b0, "ldc_rs1_bit2");
        idle_cycles(1, "directed");
        check_count("directed");
    endtask

    task automatic test_ignore_valid();
        issue(3'd1, 3'd3, 3'd1, 3'd2, 1'b1, "add_hold_valid");
        issue(3'd7, 3'd2, 3'd3, 3'd0, 1'b1, "mov_hold_valid");
        idle_cycles(2, "ignore");
        check_count("ignore");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            issue(3'($urandom_range(7)), 3'($urandom_range(7)), 3'($urandom_range(7)),
                  3'($urandom_range(7)), 1'b0, "b2b");
        end
        idle_cycles(1, "b2b");
        check_count("b2b");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(7)), 3'($urandom_range(7)), 3'($urandom_range(7)),
                  3'($urandom_range(7)), 1'($urandom_range(1)), "random");
            idle_cycles(int'($urandom_range(2)), "random_gap");
        end
        idle_cycles(1, "random");
        check_count("random");
    endtask

    task automatic test_mid_reset();
        instr_valid = 1'b1;
        instr_op    = 3'd1;
        instr_rd    = 3'd7;
        instr_rs1   = 3'd1;
        instr_rs2   = 3'd2;
        build(3'd1, 3'd7, 3'd1, 3'd2);
        @(posedge clock);
        @(negedge clock);
        instr_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL mid_reset step %0d: got %h, required %h", i, obs, exp_q[i]);
            end
            if (i < 5) @(negedge clock);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== IdleV) begin
            errors++;
            $display("FAIL mid_reset async idle: got %h, required %h", obs, IdleV);
        end
        retired = 0;
        check_count("mid_reset_async");
        idle_cycles(2, "in_reset");
        reset_n = 1'b1;
        idle_cycles(3, "after_mid_reset");
        check_count("after_mid_reset");
        issue(3'd1, 3'd7, 3'd1, 3'd2, 1'b0, "add_r7_retry");
        idle_cycles(1, "retry");
        check_count("retry");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_valid();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
